spi_byte_sequencer: RTL and testbench

- Sits directly upstream of the 8-bit SPI byte master (start/tx_byte/rx_byte/done/busy handshake).
- Turns one command, "write N bytes then read M bytes", into a series of single-byte master transfers.
- TX bytes are taken from a valid/ready stream. Read bytes go into an internal RX FIFO, which feeds a valid/ready output stream.
- Used by the command/USB layer for multi-byte SPI flash/peripheral accesses.

---
 rtl/spi_byte_sequencer.sv | 164 ++++++++++++++++
 tb/tb_spi_byte_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_sequencer.sv
// Splits a "write N bytes, then read M bytes" command into single-byte SPI master transfers.
// Read bytes collect in a first-word-fall-through RX FIFO; bytes clocked in during the write phase are dropped.
//   state      | meaning
//   S_IDLE     | waiting for a command
//   S_SEL      | choose the next write, the next read, or completion
//   S_WR_FETCH | wait for a TX byte while the master is idle
//   S_RD_ISSUE | wait for the master to be idle and a free FIFO entry
//   S_WAIT     | transfer in flight, waiting for done
//   S_FINISH   | command complete, done pulse follows
module spi_byte_sequencer #(
  parameter int         LEN_W      = 8,
  parameter logic [7:0] DUMMY_BYTE = 8'hFF,
  parameter int         RX_DEPTH   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [LEN_W-1:0] i_cmd_wr_len,
  input  logic [LEN_W-1:0] i_cmd_rd_len,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  input  logic [7:0]       i_tx_data,
  output logic             o_rx_valid,
  input  logic             i_rx_ready,
  output logic [7:0]       o_rx_data,
  output logic             o_spi_start,
  output logic [7:0]       o_spi_tx_byte,
  input  logic [7:0]       i_spi_rx_byte,
  input  logic             i_spi_done,
  input  logic             i_spi_busy,
  output logic             o_busy,
  output logic             o_cmd_done
);

  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = RX_DEPTH[PTR_W:0];

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_WR_FETCH, S_RD_ISSUE, S_WAIT, S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             tx_ready;
  logic             push, pop, fifo_full;

  logic [7:0]       mem_q [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      tx_byte_q <= 8'h00;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      tx_byte_q <= tx_byte_d;
      start_q   <= start_d;
      done_q    <= done_d;
    end
  end

  // A read only issues when no earlier read is in flight, so a non-full FIFO always has room for it.
  assign fifo_full = (cnt_q == FULL_CNT);

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    tx_byte_d = tx_byte_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    tx_ready  = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          wr_cnt_d = i_cmd_wr_len;
          rd_cnt_d = i_cmd_rd_len;
          state_d  = ((i_cmd_wr_len == '0) && (i_cmd_rd_len == '0)) ? S_FINISH : S_SEL;
        end
      end
      S_SEL: begin
        if (wr_cnt_q != '0)      state_d = S_WR_FETCH;
        else if (rd_cnt_q != '0) state_d = S_RD_ISSUE;
        else                     state_d = S_FINISH;
      end
      S_WR_FETCH: begin
        tx_ready = i_tx_valid & ~i_spi_busy;
        if (tx_ready) begin
          tx_byte_d = i_tx_data;
          start_d   = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_RD_ISSUE: begin
        if (!i_spi_busy && !fifo_full) begin
          tx_byte_d = DUMMY_BYTE;
          start_d   = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_spi_done) begin
          if (wr_cnt_q != '0) begin
            wr_cnt_d = wr_cnt_q - LEN_W'(1);
          end else begin
            push = 1'b1;
            if (rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - LEN_W'(1);
          end
          state_d = S_SEL;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop = o_rx_valid & i_rx_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_spi_rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign o_rx_valid    = (cnt_q != '0);
  assign o_rx_data     = o_rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign o_cmd_ready   = (state_q == S_IDLE);
  assign o_busy        = (state_q != S_IDLE);
  assign o_tx_ready    = tx_ready;
  assign o_spi_start   = start_q;
  assign o_spi_tx_byte = tx_byte_q;
  assign o_cmd_done    = done_q;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with a 20-cycle byte-master model, TX feeder and RX collector.
module tb_spi_byte_sequencer;

  localparam int XFER = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [7:0] i_cmd_wr_len, i_cmd_rd_len;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic [7:0] i_tx_data;
  logic       o_rx_valid;
  logic       i_rx_ready;
  logic [7:0] o_rx_data;
  logic       o_spi_start;
  logic [7:0] o_spi_tx_byte;
  logic [7:0] i_spi_rx_byte;
  logic       i_spi_done;
  logic       i_spi_busy;
  logic       o_busy;
  logic       o_cmd_done;

  spi_byte_sequencer dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_wr_len(i_cmd_wr_len), .i_cmd_rd_len(i_cmd_rd_len),
    .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready), .i_tx_data(i_tx_data),
    .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready), .o_rx_data(o_rx_data),
    .o_spi_start(o_spi_start), .o_spi_tx_byte(o_spi_tx_byte),
    .i_spi_rx_byte(i_spi_rx_byte), .i_spi_done(i_spi_done), .i_spi_busy(i_spi_busy),
    .o_busy(o_busy), .o_cmd_done(o_cmd_done)
  );

  always #5 clk = ~clk;

  logic [7:0] tx_q[$];
  logic [7:0] mrx_q[$];
  logic [7:0] start_log[$];
  logic [7:0] rx_got[$];
  logic       tx_hold = 1'b0;
  logic       force_busy = 1'b0;
  logic       m_busy = 1'b0;
  int         done_cnt = 0;
  int         done_pulses = 0;
  int         viol = 0;
  int         checks = 0;
  int         passes = 0;

  assign i_spi_busy = m_busy | force_busy;

  // Byte master: busy from the cycle after start, done on the last busy cycle, idle one cycle later.
  initial begin : master_model
    int  cnt;
    logic pending, drop, prev_start, busy_before;
    cnt = 0; pending = 0; drop = 0; prev_start = 0;
    i_spi_done = 1'b0;
    i_spi_rx_byte = 8'h00;
    forever begin
      @(negedge clk);
      busy_before = m_busy | force_busy;
      i_spi_done = 1'b0;
      if (drop) begin
        m_busy = 1'b0;
        drop = 0;
      end else if (m_busy) begin
        cnt--;
        if (cnt == 0) begin
          i_spi_done = 1'b1;
          i_spi_rx_byte = (mrx_q.size() > 0) ? mrx_q.pop_front() : 8'h00;
          drop = 1;
          done_pulses++;
        end
      end
      if (pending) begin
        m_busy = 1'b1;
        cnt = XFER;
        pending = 0;
      end
      if (o_spi_start) begin
        if (busy_before || m_busy || force_busy || prev_start) viol++;
        start_log.push_back(o_spi_tx_byte);
        pending = 1;
      end
      prev_start = o_spi_start;
    end
  end

  initial begin : tx_feeder
    i_tx_valid = 1'b0;
    i_tx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_q.size() > 0 && !tx_hold) begin
        i_tx_valid = 1'b1;
        i_tx_data = tx_q[0];
      end else begin
        i_tx_valid = 1'b0;
      end
      #4;
      if (i_tx_valid && o_tx_ready) void'(tx_q.pop_front());
    end
  end

  initial begin : rx_collector
    forever begin
      @(negedge clk);
      #4;
      if (o_rx_valid && i_rx_ready) rx_got.push_back(o_rx_data);
    end
  end

  initial begin : done_monitor
    forever begin
      @(negedge clk);
      if (o_cmd_done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] wr, input logic [7:0] rd);
    @(negedge clk);
    chk("cmd_ready_before_send", {31'd0, o_cmd_ready}, 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd_wr_len = wr;
    i_cmd_rd_len = rd;
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (o_busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, o_busy}, 32'd0);
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (start_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, start_log.size(), n);
  endtask

  task automatic clear_logs();
    start_log.delete();
    rx_got.delete();
    done_cnt = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, o_cmd_ready}, 32'd1);
    chk({tag, "_tx_ready"},  {31'd0, o_tx_ready},  32'd0);
    chk({tag, "_rx_valid"},  {31'd0, o_rx_valid},  32'd0);
    chk({tag, "_rx_data"},   {24'd0, o_rx_data},   32'd0);
    chk({tag, "_start"},     {31'd0, o_spi_start}, 32'd0);
    chk({tag, "_tx_byte"},   {24'd0, o_spi_tx_byte}, 32'd0);
    chk({tag, "_busy"},      {31'd0, o_busy},      32'd0);
    chk({tag, "_cmd_done"},  {31'd0, o_cmd_done},  32'd0);
  endtask

  initial begin : stimulus
    int pulses_before;
    rst = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_wr_len = 8'd0;
    i_cmd_rd_len = 8'd0;
    i_rx_ready = 1'b1;
    cycles(3);
    chk_reset_outputs("reset");
    rst = 1'b0;
    cycles(2);

    // Two writes, no reads
    clear_logs();
    tx_q = '{8'hA5, 8'h3C};
    send_cmd(8'd2, 8'd0);
    wait_idle("wr2_timeout", 200);
    cycles(3);
    chk("wr2_starts", start_log.size(), 2);
    chk("wr2_byte0", {24'd0, start_log[0]}, 32'hA5);
    chk("wr2_byte1", {24'd0, start_log[1]}, 32'h3C);
    chk("wr2_rx_none", rx_got.size(), 0);
    chk("wr2_done_cnt", done_cnt, 1);

    // One write then three reads; the write-phase rx byte must be dropped
    clear_logs();
    tx_q = '{8'h9F};
    mrx_q = '{8'h11, 8'hEF, 8'h40, 8'h18};
    send_cmd(8'd1, 8'd3);
    wait_idle("wr1rd3_timeout", 300);
    cycles(3);
    chk("wr1rd3_starts", start_log.size(), 4);
    chk("wr1rd3_b0", {24'd0, start_log[0]}, 32'h9F);
    chk("wr1rd3_b1", {24'd0, start_log[1]}, 32'hFF);
    chk("wr1rd3_b2", {24'd0, start_log[2]}, 32'hFF);
    chk("wr1rd3_b3", {24'd0, start_log[3]}, 32'hFF);
    chk("wr1rd3_rx_cnt", rx_got.size(), 3);
    chk("wr1rd3_rx0", {24'd0, rx_got[0]}, 32'hEF);
    chk("wr1rd3_rx1", {24'd0, rx_got[1]}, 32'h40);
    chk("wr1rd3_rx2", {24'd0, rx_got[2]}, 32'h18);
    chk("wr1rd3_done_cnt", done_cnt, 1);

    // Empty command: done two cycles after acceptance
    clear_logs();
    send_cmd(8'd0, 8'd0);
    chk("empty_c1_done", {31'd0, o_cmd_done}, 32'd0);
    chk("empty_c1_busy", {31'd0, o_busy}, 32'd1);
    @(negedge clk);
    chk("empty_c2_done", {31'd0, o_cmd_done}, 32'd1);
    chk("empty_c2_busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    chk("empty_c3_done", {31'd0, o_cmd_done}, 32'd0);
    chk("empty_starts", start_log.size(), 0);

    // Twenty reads into a 16-deep FIFO with no consumer
    clear_logs();
    i_rx_ready = 1'b0;
    mrx_q.delete();
    for (int i = 0; i < 20; i++) mrx_q.push_back(8'h50 + 8'(i));
    send_cmd(8'd0, 8'd20);
    cycles(700);
    chk("rd20_stall_starts", start_log.size(), 16);
    chk("rd20_stall_busy", {31'd0, o_busy}, 32'd1);
    chk("rd20_stall_rx_valid", {31'd0, o_rx_valid}, 32'd1);
    chk("rd20_stall_head", {24'd0, o_rx_data}, 32'h50);
    i_rx_ready = 1'b1;
    wait_idle("rd20_timeout", 400);
    cycles(4);
    chk("rd20_starts", start_log.size(), 20);
    chk("rd20_rx_cnt", rx_got.size(), 20);
    for (int i = 0; i < 20; i++) begin
      if (i < rx_got.size()) chk("rd20_rx_order", {24'd0, rx_got[i]}, 32'h50 + i);
    end
    chk("rd20_drained", {31'd0, o_rx_valid}, 32'd0);
    chk("rd20_done_cnt", done_cnt, 1);

    // TX stream pause and master held busy during the write phase
    clear_logs();
    tx_q = '{8'hC1, 8'hC2, 8'hC3};
    send_cmd(8'd3, 8'd0);
    wait_starts("stall_first_start", 1, 50);
    tx_hold = 1'b1;
    cycles(40);
    chk("txhold_starts", start_log.size(), 1);
    chk("txhold_tx_ready", {31'd0, o_tx_ready}, 32'd0);
    force_busy = 1'b1;
    tx_hold = 1'b0;
    cycles(12);
    chk("forcebusy_starts", start_log.size(), 1);
    chk("forcebusy_tx_ready", {31'd0, o_tx_ready}, 32'd0);
    force_busy = 1'b0;
    wait_idle("stall_timeout", 200);
    cycles(3);
    chk("stall_starts", start_log.size(), 3);
    chk("stall_b1", {24'd0, start_log[1]}, 32'hC2);
    chk("stall_b2", {24'd0, start_log[2]}, 32'hC3);
    chk("stall_done_cnt", done_cnt, 1);

    // Reset in WAIT with three bytes buffered, then a late done from the master
    clear_logs();
    i_rx_ready = 1'b0;
    mrx_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_cmd(8'd0, 8'd5);
    wait_starts("rst_fourth_start", 4, 200);
    cycles(5);
    chk("prerst_rx_valid", {31'd0, o_rx_valid}, 32'd1);
    chk("prerst_head", {24'd0, o_rx_data}, 32'hA1);
    pulses_before = done_pulses;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    cycles(25);
    chk("late_done_seen", done_pulses, pulses_before + 1);
    chk("late_done_busy", {31'd0, o_busy}, 32'd0);
    chk("late_done_rx_valid", {31'd0, o_rx_valid}, 32'd0);
    chk("late_done_cmd_done", done_cnt, 0);

    clear_logs();
    i_rx_ready = 1'b1;
    tx_q = '{8'h5A};
    mrx_q = '{8'h00, 8'h77};
    send_cmd(8'd1, 8'd1);
    wait_idle("postrst_timeout", 200);
    cycles(3);
    chk("postrst_starts", start_log.size(), 2);
    chk("postrst_b0", {24'd0, start_log[0]}, 32'h5A);
    chk("postrst_b1", {24'd0, start_log[1]}, 32'hFF);
    chk("postrst_rx_cnt", rx_got.size(), 1);
    chk("postrst_rx0", {24'd0, rx_got[0]}, 32'h77);
    chk("postrst_done_cnt", done_cnt, 1);

    chk("start_protocol", viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
